// File: rtl/alu_ctrl_mc.sv
// ALU control decode with a registered single-cycle code map and a shift-add
// multiply sequencer; ready_o stalls issue while a multiply is in flight.
module alu_ctrl_mc #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [5:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [3:0]       ALUCtrl_o,
  output logic             ctrl_valid_o,
  output logic             illegal_o,
  output logic             mul_busy_o,
  output logic             mul_done_o,
  output logic [WIDTH-1:0] mul_result_o
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [CW-1:0]    cnt;

  logic [3:0]       dec_code;
  logic             dec_ill, dec_mul;
  logic [WIDTH-1:0] acc_nxt, b_nxt;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    dec_code = 4'b1111;
    dec_ill  = 1'b1;
    dec_mul  = 1'b0;
    case (ALUOp_i)
      2'b00: begin dec_code = 4'b0000; dec_ill = 1'b0; end
      2'b01: begin dec_code = 4'b0001; dec_ill = 1'b0; end
      2'b10: begin
        case (funct_i)
          6'b100011: begin dec_code = 4'b0000; dec_ill = 1'b0; end
          6'b100001: begin dec_code = 4'b0001; dec_ill = 1'b0; end
          6'b100110: begin dec_code = 4'b0010; dec_ill = 1'b0; end
          6'b100101: begin dec_code = 4'b0011; dec_ill = 1'b0; end
          6'b101011: begin dec_code = 4'b0100; dec_ill = 1'b0; end
          6'b101000: begin dec_code = 4'b0101; dec_ill = 1'b0; end
          6'b011000: begin
            if (MUL_EN) begin
              dec_code = 4'b0110;
              dec_ill  = 1'b0;
              dec_mul  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // One shift-add step; the exit test looks at the post-step multiplier.
  assign acc_nxt = op_b[0] ? acc + op_a : acc;
  assign b_nxt   = op_b >> 1;
  assign cnt_nxt = cnt + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      cnt          <= '0;
      ready_o      <= 1'b1;
      ALUCtrl_o    <= 4'b1111;
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      mul_busy_o   <= 1'b0;
      mul_done_o   <= 1'b0;
      mul_result_o <= '0;
    end else begin
      ctrl_valid_o <= 1'b0;
      illegal_o    <= 1'b0;
      mul_done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            ALUCtrl_o <= dec_code;
            if (dec_mul) begin
              op_a       <= src_a_i;
              op_b       <= src_b_i;
              acc        <= '0;
              cnt        <= '0;
              ready_o    <= 1'b0;
              mul_busy_o <= 1'b1;
              state      <= MUL;
            end else begin
              ctrl_valid_o <= 1'b1;
              illegal_o    <= dec_ill;
            end
          end
        end
        MUL: begin
          acc  <= acc_nxt;
          op_a <= op_a << 1;
          op_b <= b_nxt;
          cnt  <= cnt_nxt;
          // Result and done are registered here so they are visible during DONE.
          if (b_nxt == '0 || cnt_nxt == CW'(WIDTH)) begin
            mul_busy_o   <= 1'b0;
            mul_done_o   <= 1'b1;
            mul_result_o <= acc_nxt;
            state        <= DONE;
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed bench for alu_ctrl_mc: decode map, multiply timing/results, stall and reset abort.
module tb_alu_ctrl_mc;
  logic        clk = 1'b0;
  logic        rst, valid, valid2;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic [31:0] src_a, src_b;

  logic        ready, cv, ill, busy, done;
  logic [3:0]  ctrl;
  logic [31:0] res;
  logic        ready2, cv2, ill2, busy2, done2;
  logic [3:0]  ctrl2;
  logic [31:0] res2;

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .funct_i(funct), .ALUOp_i(aluop), .src_a_i(src_a), .src_b_i(src_b),
    .ALUCtrl_o(ctrl), .ctrl_valid_o(cv), .illegal_o(ill), .mul_busy_o(busy),
    .mul_done_o(done), .mul_result_o(res));

  alu_ctrl_mc #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk_i(clk), .rst_i(rst), .valid_i(valid2), .ready_o(ready2),
    .funct_i(funct), .ALUOp_i(aluop), .src_a_i(src_a), .src_b_i(src_b),
    .ALUCtrl_o(ctrl2), .ctrl_valid_o(cv2), .illegal_o(ill2), .mul_busy_o(busy2),
    .mul_done_o(done2), .mul_result_o(res2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Accept a multiply, then run until ready returns; valid may be held throughout.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         output int cycles, output int ndone, output int ncv,
                         output logic [31:0] r);
    cycles = 0; ndone = 0; ncv = 0; r = '0;
    aluop = 2'b10; funct = 6'b011000; src_a = a; src_b = b; valid = 1'b1;
    step();
    if (!hold) valid = 1'b0;
    src_a = 32'h1234; src_b = 32'h5678;
    while (!ready && cycles < 200) begin
      if (done) begin ndone++; r = res; end
      if (cv) ncv++;
      cycles++;
      step();
    end
    valid = 1'b0;
  endtask

  typedef struct { logic [1:0] op; logic [5:0] f; logic [3:0] code; logic il; } vec_t;
  vec_t vecs[10] = '{
    '{2'b00, 6'b000000, 4'b0000, 1'b0}, '{2'b01, 6'b111111, 4'b0001, 1'b0},
    '{2'b10, 6'b100011, 4'b0000, 1'b0}, '{2'b10, 6'b100001, 4'b0001, 1'b0},
    '{2'b10, 6'b100101, 4'b0011, 1'b0}, '{2'b10, 6'b101011, 4'b0100, 1'b0},
    '{2'b10, 6'b101000, 4'b0101, 1'b0}, '{2'b10, 6'b000000, 4'b1111, 1'b1},
    '{2'b11, 6'b100011, 4'b1111, 1'b1}, '{2'b00, 6'b100110, 4'b0000, 1'b0}};

  initial begin
    int cyc, nd, ncv;
    logic [31:0] r;
    rst = 1'b1; valid = 1'b0; valid2 = 1'b0; funct = '0; aluop = '0; src_a = '0; src_b = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_ready", ready, 1);
    chk("rst_ctrl", ctrl, 4'b1111);
    chk("rst_res", res, 0);
    chk("rst_pulses", {cv, ill, busy, done}, 0);

    aluop = 2'b10; funct = 6'b100110; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("and_ctrl", ctrl, 4'b0010);
    chk("and_cv", cv, 1);
    chk("and_ill", ill, 0);
    step();
    chk("and_cv_drop", cv, 0);
    chk("and_ctrl_hold", ctrl, 4'b0010);

    // Back-to-back single-cycle decodes, one per cycle.
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      aluop = vecs[i].op; funct = vecs[i].f;
      step();
      chk($sformatf("b2b%0d_ctrl", i), ctrl, vecs[i].code);
      chk($sformatf("b2b%0d_cv", i), cv, 1);
      chk($sformatf("b2b%0d_ill", i), ill, vecs[i].il);
      chk($sformatf("b2b%0d_ready", i), ready, 1);
    end
    valid = 1'b0;
    step();

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, cyc, nd, ncv, r);
    chk("mff_cycles", cyc, 33);
    chk("mff_done", nd, 1);
    chk("mff_cv", ncv, 0);
    chk("mff_res", r, 32'h00000001);
    step();
    chk("mff_no_reaccept", ready, 1);
    chk("mff_res_hold", res, 32'h00000001);

    run_mul(32'd5, 32'd0, 1'b0, cyc, nd, ncv, r);
    chk("mb0_cycles", cyc, 2);
    chk("mb0_done", nd, 1);
    chk("mb0_res", r, 0);

    aluop = 2'b10; funct = 6'b011000; src_a = 32'd6; src_b = 32'd7; valid = 1'b1;
    step();
    valid = 1'b0;
    chk("m67_ctrl", ctrl, 4'b0110);
    chk("m67_busy", busy, 1);
    chk("m67_cv", cv, 0);
    cyc = 0; nd = 0;
    while (!ready && cyc < 200) begin
      if (done) begin nd++; r = res; end
      cyc++;
      step();
    end
    chk("m67_cycles", cyc, 4);
    chk("m67_done", nd, 1);
    chk("m67_res", r, 42);
    chk("m67_ctrl_after", ctrl, 4'b0110);
    chk("m67_busy_after", busy, 0);

    valid2 = 1'b1; aluop = 2'b10; funct = 6'b011000;
    step();
    valid2 = 1'b0;
    chk("nomul_ctrl", ctrl2, 4'b1111);
    chk("nomul_ill", ill2, 1);
    chk("nomul_cv", cv2, 1);
    chk("nomul_ready", ready2, 1);
    chk("nomul_busy", busy2, 0);

    // Abort a 32-cycle multiply during its 5th MUL cycle.
    aluop = 2'b10; funct = 6'b011000; src_a = 32'd3; src_b = 32'h80000000; valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (4) step();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_ctrl", ctrl, 4'b1111);
    chk("abort_res", res, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      step();
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
